// File: rtl/sobel_window_linebuf.sv
// Streaming 3x3 window generator for the Sobel stage: two line RAMs hold the
// previous rows, two column registers hold the previous columns, and one output
// register presents each interior window with its centre coordinates.
module sobel_window_linebuf #(
    parameter  int ROWS = 242,
    parameter  int COLS = 247,
    localparam int RW   = $clog2(ROWS),
    localparam int CW   = $clog2(COLS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sof,
    input  logic [7:0]    in_pixel,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [71:0]   out_window,
    output logic [RW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          out_last,
    output logic          frame_done,
    output logic          sof_err
);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH} state_t;

    // One vertical slice of the window: rows r-2, r-1 and r at a single column.
    typedef struct packed {
        logic [7:0] top;
        logic [7:0] mid;
        logic [7:0] bot;
    } column_t;

    state_t         state, state_next;
    logic           frame_done_next;
    logic [RW-1:0]  row;
    logic [CW-1:0]  col;
    logic [7:0]     lb0 [COLS];
    logic [7:0]     lb1 [COLS];
    column_t        hist0, hist1, new_col;

    logic           accept, start, take, emit, at_end;
    logic [RW-1:0]  eff_row;
    logic [CW-1:0]  eff_col;

    // A pixel carrying in_sof always lands at (0,0), wherever the counters were.
    assign in_ready = (state != S_FLUSH) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign start    = accept && in_sof;
    assign take     = accept && (in_sof || state == S_STREAM);
    assign eff_row  = in_sof ? '0 : row;
    assign eff_col  = in_sof ? '0 : col;
    assign emit     = take && (eff_row >= RW'(2)) && (eff_col >= CW'(2));
    assign at_end   = take && (eff_row == RW'(ROWS - 1)) && (eff_col == CW'(COLS - 1));

    // Incoming column: the two buffered rows above plus the arriving pixel.
    always_comb begin
        new_col.top = lb0[eff_col];
        new_col.mid = lb1[eff_col];
        new_col.bot = in_pixel;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            // NOTE: every clocked assignment uses <= so all flops sample the same pre-edge values.
            state <= state_next;
        end
    end

    // Next-state decode; S_FLUSH waits for the last window to leave before re-arming.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
        state_next      = state;
        frame_done_next = 1'b0;
        case (state)
            S_IDLE:   if (start) state_next = S_STREAM;
            S_STREAM: if (at_end) state_next = S_FLUSH;
            S_FLUSH: begin
                if (out_valid && out_ready && out_last) begin
                    state_next      = S_IDLE;
                    frame_done_next = 1'b1;
                end
            end
            default:  state_next = S_IDLE;
        endcase
    end

    // Line RAMs shift one row down per accepted pixel (read-before-write on the same column).
    always_ff @(posedge clk) begin
        // NOTE: no reset on the RAMs; stale rows are overwritten before any window uses them.
        if (take) begin
            lb0[eff_col] <= lb1[eff_col];
            lb1[eff_col] <= in_pixel;
        end
    end

    // Position counters, column history, output register and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row        <= '0;
            col        <= '0;
            hist0      <= '0;
            hist1      <= '0;
            out_valid  <= 1'b0;
            out_window <= '0;
            out_row    <= '0;
            out_col    <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            frame_done <= frame_done_next;
            sof_err    <= start && (state == S_STREAM);

            if (take) begin
                // Column 0 starts a fresh history so rows never mix across the wrap.
                hist0 <= (eff_col == '0) ? '0 : hist1;
                hist1 <= new_col;
                if (at_end) begin
                    row <= '0;
                    col <= '0;
                end else if (eff_col == CW'(COLS - 1)) begin
                    row <= eff_row + RW'(1);
                    col <= '0;
                end else begin
                    row <= eff_row;
                    col <= eff_col + CW'(1);
                end
            end

            if (emit) begin
                out_valid  <= 1'b1;
                out_window <= {new_col.bot, hist1.bot, hist0.bot,
                               new_col.mid, hist1.mid, hist0.mid,
                               new_col.top, hist1.top, hist0.top};
                out_row    <= eff_row - RW'(1);
                out_col    <= eff_col - CW'(1);
                out_last   <= at_end;
            end else if (out_ready) begin
                out_valid  <= 1'b0;
            end
        end
    end

endmodule
